// File: rtl/clock_chime.sv
// Hourly strike and daily alarm sequencer driving a single buzzer from the
// BCD time counts; all timing is derived from the 1 kHz CP clock.
module clock_chime #(
  parameter int unsigned ALARM_SECS = 60,
  parameter int unsigned DEB_CYC    = 20
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic [7:0] AlmHour,
  input  logic [7:0] AlmMin,
  input  logic       AlmEN,
  input  logic       StopKey,
  output logic       Buzz,
  output logic       Chiming,
  output logic       Alarming
);

  typedef enum logic {IDLE, ALARM} state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);
  localparam logic [7:0] REM_INIT = 8'(ALARM_SECS);

  state_t      state;
  logic [23:0] s1, s2, cur;
  logic [1:0]  div;
  logic [9:0]  ms;
  logic [7:0]  rem;
  logic        key_s1, key_s2, key_db, key_db_q;
  logic [7:0]  deb_cnt;

  logic [23:0] cur_n;
  logic [1:0]  div_n;
  logic [9:0]  ms_n;
  logic        tick, gate, stop_pulse;
  logic        chime_lo, chime_hi, chime_buzz, alm_match, alarm_next;

  // Decisions look at the value cur takes on this edge so the output register
  // lands on the third edge after the inputs change.
  always_comb begin
    tick  = (s1 == s2) && (s2 != cur);
    cur_n = tick ? s2 : cur;
    div_n = div + 2'd1;
    if (tick)
      ms_n = '0;
    else if (ms == 10'd999)
      ms_n = ms;
    else
      ms_n = ms + 10'd1;
    gate = (ms_n < 10'd500);
  end

  always_comb begin
    chime_lo = 1'b0;
    chime_hi = 1'b0;
    if (cur_n[15:8] == 8'h59) begin
      chime_lo = (cur_n[7:0] == 8'h51) || (cur_n[7:0] == 8'h53) ||
                 (cur_n[7:0] == 8'h55) || (cur_n[7:0] == 8'h57);
      chime_hi = (cur_n[7:0] == 8'h59);
    end
    if (chime_lo)
      chime_buzz = div_n[1];
    else if (chime_hi)
      chime_buzz = div_n[0];
    else
      chime_buzz = 1'b0;
  end

  always_comb begin
    stop_pulse = key_db & ~key_db_q;
    alm_match  = tick && AlmEN && (cur_n == {AlmHour, AlmMin, 8'h00});
    if (state == IDLE)
      alarm_next = alm_match;
    else
      alarm_next = !(stop_pulse || !AlmEN || (tick && (rem == 8'd1)));
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      s1  <= '0;
      s2  <= '0;
      cur <= '0;
      div <= '0;
      ms  <= '0;
    end else begin
      s1  <= {Hour, Minute, Second};
      s2  <= s1;
      cur <= cur_n;
      div <= div_n;
      ms  <= ms_n;
    end
  end

  // Key must differ from the debounced level for DEB_CYC straight cycles.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      key_s1   <= 1'b0;
      key_s2   <= 1'b0;
      key_db   <= 1'b0;
      key_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      key_s1   <= StopKey;
      key_s2   <= key_s1;
      key_db_q <= key_db;
      if (key_s2 != key_db) begin
        if (deb_cnt == DEB_LAST) begin
          key_db  <= key_s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 8'd1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state    <= IDLE;
      rem      <= '0;
      Buzz     <= 1'b0;
      Chiming  <= 1'b0;
      Alarming <= 1'b0;
    end else begin
      state <= alarm_next ? ALARM : IDLE;
      if (state == IDLE) begin
        if (alm_match)
          rem <= REM_INIT;
      end else if (!alarm_next) begin
        rem <= '0;
      end else if (tick) begin
        rem <= rem - 8'd1;
      end
      if (alarm_next) begin
        Buzz     <= div_n[0] & gate;
        Chiming  <= 1'b0;
        Alarming <= 1'b1;
      end else begin
        Buzz     <= chime_buzz;
        Chiming  <= chime_lo | chime_hi;
        Alarming <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_chime.sv
// Scoreboard bench for clock_chime: expected buzzer/flag values are queued
// per clock edge as time values are driven and compared after each edge.
module tb_clock_chime;

  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic [7:0] Hour = '0, Minute = '0, Second = '0;
  logic [7:0] AlmHour = '0, AlmMin = '0;
  logic       AlmEN = 1'b0, StopKey = 1'b0;
  logic       Buzz, Chiming, Alarming;

  clock_chime #(.ALARM_SECS(3), .DEB_CYC(20)) dut (
    .CP(CP), .nCR(nCR), .Hour(Hour), .Minute(Minute), .Second(Second),
    .AlmHour(AlmHour), .AlmMin(AlmMin), .AlmEN(AlmEN), .StopKey(StopKey),
    .Buzz(Buzz), .Chiming(Chiming), .Alarming(Alarming)
  );

  always #5 CP = ~CP;

  typedef enum int {M_SIL, M_LO, M_HI, M_ALM} mode_t;
  typedef struct {int cyc; logic buzz; logic chim; logic alm; string nm;} exp_t;
  typedef struct {logic [7:0] h; logic [7:0] m; logic [7:0] s; mode_t md; string nm;} vec_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   base = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s @cyc %0d: buzz/chiming/alarming got %b want %b", nm, cyc, got, want);
  endtask

  always @(posedge CP) begin
    exp_t e;
    cyc++;
    #1;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      chk(e.nm, {Buzz, Chiming, Alarming}, {e.buzz, e.chim, e.alm});
    end
  end

  function automatic logic hi_at(input int e);
    int d = e - base;
    return d[0];
  endfunction

  function automatic logic lo_at(input int e);
    int d = e - base;
    return d[1];
  endfunction

  task automatic push(input int e, input logic b, input logic c, input logic a, input string nm);
    exp_t x;
    x.cyc = e; x.buzz = b; x.chim = c; x.alm = a; x.nm = nm;
    sbq.push_back(x);
  endtask

  // Drive a time for n cycles; its outputs occupy edges cyc+3 .. cyc+n+2.
  task automatic hold(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                      input int n, input mode_t md, input string nm);
    int t;
    Hour = h; Minute = m; Second = s;
    t = cyc + 3;
    for (int k = 0; k < n; k++) begin
      case (md)
        M_SIL: push(t + k, 1'b0, 1'b0, 1'b0, nm);
        M_LO:  push(t + k, lo_at(t + k), 1'b1, 1'b0, nm);
        M_HI:  push(t + k, hi_at(t + k), 1'b1, 1'b0, nm);
        default: push(t + k, hi_at(t + k) & (k < 500), 1'b0, 1'b1, nm);
      endcase
    end
    repeat (n) @(negedge CP);
  endtask

  task automatic drain();
    repeat (2) @(negedge CP);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   s0, d;
    tbl[0]  = '{8'h10, 8'h59, 8'h50, M_SIL, "strike_50"};
    tbl[1]  = '{8'h10, 8'h59, 8'h51, M_LO,  "strike_51"};
    tbl[2]  = '{8'h10, 8'h59, 8'h52, M_SIL, "strike_52"};
    tbl[3]  = '{8'h10, 8'h59, 8'h53, M_LO,  "strike_53"};
    tbl[4]  = '{8'h10, 8'h59, 8'h54, M_SIL, "strike_54"};
    tbl[5]  = '{8'h10, 8'h59, 8'h55, M_LO,  "strike_55"};
    tbl[6]  = '{8'h10, 8'h59, 8'h56, M_SIL, "strike_56"};
    tbl[7]  = '{8'h10, 8'h59, 8'h57, M_LO,  "strike_57"};
    tbl[8]  = '{8'h10, 8'h59, 8'h58, M_SIL, "strike_58"};
    tbl[9]  = '{8'h10, 8'h59, 8'h59, M_HI,  "strike_59"};
    tbl[10] = '{8'h11, 8'h00, 8'h00, M_ALM, "alarm_after_strike"};

    repeat (2) @(negedge CP);
    chk("reset_state", {Buzz, Chiming, Alarming}, 3'b000);
    nCR = 1'b1; base = cyc;

    // Asynchronous reset in the middle of a beep
    hold(8'h10, 8'h59, 8'h51, 20, M_LO, "pre_reset_beep");
    drain();
    #2 nCR = 1'b0;
    #1 chk("async_reset", {Buzz, Chiming, Alarming}, 3'b000);
    Hour = 8'h12; Minute = 8'h34; Second = 8'h56;
    repeat (2) @(negedge CP);
    chk("reset_held", {Buzz, Chiming, Alarming}, 3'b000);
    nCR = 1'b1; base = cyc;
    hold(8'h12, 8'h34, 8'h56, 20, M_SIL, "after_reset");
    drain();

    // Hourly strike, with an alarm at 11:00 that must start only at 11:00:00
    AlmHour = 8'h11; AlmMin = 8'h00; AlmEN = 1'b1;
    for (int i = 0; i < 11; i++)
      hold(tbl[i].h, tbl[i].m, tbl[i].s, 16, tbl[i].md, tbl[i].nm);
    drain();
    AlmEN = 1'b0; d = cyc;
    for (int k = 1; k <= 3; k++) push(d + k, 1'b0, 1'b0, 1'b0, "almen_off_exit");
    repeat (3) @(negedge CP);

    // Alarm timeout after three seconds with 500/500 gating
    AlmHour = 8'h07; AlmMin = 8'h30; AlmEN = 1'b1;
    hold(8'h07, 8'h29, 8'h59, 10, M_SIL, "pre_alarm");
    hold(8'h07, 8'h30, 8'h00, 1000, M_ALM, "alarm_s0");
    hold(8'h07, 8'h30, 8'h01, 1000, M_ALM, "alarm_s1");
    hold(8'h07, 8'h30, 8'h02, 1000, M_ALM, "alarm_s2");
    hold(8'h07, 8'h30, 8'h03, 20, M_SIL, "alarm_timeout");
    drain();

    // Stop key with bounce: Alarming falls 23 edges after the final rise
    hold(8'h07, 8'h29, 8'h59, 10, M_SIL, "pre_stop");
    d = cyc + 3;
    hold(8'h07, 8'h30, 8'h00, 50, M_ALM, "stop_ring");
    s0 = cyc;
    for (int i = 0; i < 90; i++) begin
      int  e;
      logic a;
      StopKey = (i < 30) ? ((i % 6) < 3) : (i < 60);
      e = cyc + 3;
      a = (e < s0 + 53);
      push(e, a ? (hi_at(e) & ((e - d) < 500)) : 1'b0, 1'b0, a, "stop_debounce");
      @(negedge CP);
    end
    hold(8'h07, 8'h30, 8'h01, 20, M_SIL, "no_retrigger_01");
    hold(8'h07, 8'h30, 8'h02, 20, M_SIL, "no_retrigger_02");
    drain();

    // One-cycle glitch to second 00 must not trigger
    hold(8'h07, 8'h30, 8'h45, 20, M_SIL, "glitch_pre");
    Second = 8'h00;
    push(cyc + 3, 1'b0, 1'b0, 1'b0, "glitch");
    @(negedge CP);
    hold(8'h07, 8'h30, 8'h45, 30, M_SIL, "glitch_post");
    drain();

    // Non-BCD alarm hour never matches
    AlmHour = 8'h2A;
    hold(8'h07, 8'h29, 8'h59, 10, M_SIL, "nonbcd_pre");
    hold(8'h07, 8'h30, 8'h00, 20, M_SIL, "nonbcd_hour");
    drain();

    // Arming mid-minute does not fire
    AlmEN = 1'b0; AlmHour = 8'h07; AlmMin = 8'h31;
    hold(8'h07, 8'h31, 8'h00, 10, M_SIL, "disarmed_match");
    AlmEN = 1'b1;
    hold(8'h07, 8'h31, 8'h01, 10, M_SIL, "armed_mid_minute");
    hold(8'h07, 8'h31, 8'h02, 10, M_SIL, "armed_mid_minute");
    drain();

    // Alarm suppresses the chime; dropping AlmEN lets the strike resume
    AlmHour = 8'h06; AlmMin = 8'h59; AlmEN = 1'b1;
    hold(8'h06, 8'h58, 8'h59, 10, M_SIL, "prio_pre");
    hold(8'h06, 8'h59, 8'h00, 30, M_ALM, "prio_alarm_00");
    hold(8'h06, 8'h59, 8'h51, 20, M_ALM, "prio_alarm_51");
    drain();
    AlmEN = 1'b0; d = cyc;
    for (int k = 1; k <= 12; k++) push(d + k, lo_at(d + k), 1'b1, 1'b0, "prio_resume_51");
    repeat (10) @(negedge CP);
    hold(8'h06, 8'h59, 8'h52, 12, M_SIL, "prio_52");
    hold(8'h06, 8'h59, 8'h53, 12, M_LO,  "prio_53");
    hold(8'h06, 8'h59, 8'h54, 12, M_SIL, "prio_54");
    hold(8'h06, 8'h59, 8'h55, 12, M_LO,  "prio_55");
    drain();

    total_cnt++;
    if (sbq.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
